// File: rtl/irq_gateway_if.sv
// Register-port bundle between the trap-handler bus master and irq_gateway.
// The master issues one-cycle read/write strobes; read data returns combinationally.
interface irq_gateway_if;
    logic        i_RE;
    logic        i_WE;
    logic [4:0]  i_ADDR;
    logic [31:0] i_WDATA;
    logic [31:0] o_RDATA;

    modport master (output i_RE, output i_WE, output i_ADDR, output i_WDATA, input o_RDATA);
    modport slave  (input i_RE, input i_WE, input i_ADDR, input i_WDATA, output o_RDATA);
endinterface

// File: rtl/irq_gateway.sv
// External-interrupt gateway: per-source edge/level capture, pending/in-service tracking, claim/complete.
// Define IRQ_GW_SYNC_EN for a two-flop synchroniser on i_SRC; otherwise i_SRC is registered once.
module irq_gateway #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic [N_SRC-1:0] i_SRC,
    irq_gateway_if.slave     bus,
    output logic [N_SRC-1:0] o_MEI,
    output logic             o_IRQ_ANY
);
    localparam logic [4:0] ADDR_MODE      = 5'h00;
    localparam logic [4:0] ADDR_PENDING   = 5'h04;
    localparam logic [4:0] ADDR_CLAIM     = 5'h08;
    localparam logic [4:0] ADDR_COMPLETE  = 5'h0C;
    localparam logic [4:0] ADDR_INSERVICE = 5'h10;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERV} state_t;

    logic [N_SRC-1:0] s_p1;
    logic [N_SRC-1:0] sp_p2;
    logic [N_SRC-1:0] mode_q;
    state_t           state_q [N_SRC];
    state_t           state_d [N_SRC];
    logic [N_SRC-1:0] defer_q;
    logic [N_SRC-1:0] defer_d;
    logic [N_SRC-1:0] edge_ev;
    logic [N_SRC-1:0] lvl;
    logic [N_SRC-1:0] pend_vec;
    logic [N_SRC-1:0] serv_vec;
    logic [N_SRC-1:0] claim_hit;
    logic [N_SRC-1:0] cmp_hit;
    logic [N_SRC-1:0] mei_d;
    logic             claim_rd;
    logic             cmp_wr;
    logic             mode_wr;
    logic [ID_W-1:0]  claim_id;
    logic [ID_W-1:0]  cmp_id;
    logic [31:0]      rdata;
    logic             unused_wdata;

    function automatic logic [ID_W-1:0] lowest_id(input logic [N_SRC-1:0] v);
        lowest_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (v[i]) lowest_id = ID_W'(i + 1);
    endfunction

    // Stage p0/p1: bring raw sources into the clock domain
`ifdef IRQ_GW_SYNC_EN
    logic [N_SRC-1:0] meta_p0;
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            meta_p0 <= '0;
            s_p1    <= '0;
        end else begin
            meta_p0 <= i_SRC;
            s_p1    <= meta_p0;
        end
    end
`else
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) s_p1 <= '0;
        else         s_p1 <= i_SRC;
    end
`endif

    // Stage p2: previous sample for rising-edge detection
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) sp_p2 <= '0;
        else         sp_p2 <= s_p1;
    end

    assign edge_ev      = s_p1 & ~sp_p2;
    assign lvl          = s_p1;
    assign claim_rd     = bus.i_RE && (bus.i_ADDR == ADDR_CLAIM);
    assign cmp_wr       = bus.i_WE && (bus.i_ADDR == ADDR_COMPLETE);
    assign mode_wr      = bus.i_WE && (bus.i_ADDR == ADDR_MODE);
    assign cmp_id       = bus.i_WDATA[ID_W-1:0];
    assign unused_wdata = ^bus.i_WDATA;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pend_vec[i] = (state_q[i] == ST_PEND);
            serv_vec[i] = (state_q[i] == ST_SERV);
        end
    end

    assign claim_id = lowest_id(pend_vec);

    // Ids 0 and > N_SRC never match any source, so bad completes fall out naturally
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            claim_hit[i] = claim_rd && (claim_id == ID_W'(i + 1));
            cmp_hit[i]   = cmp_wr && (cmp_id == ID_W'(i + 1));
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            state_d[i] = state_q[i];
            defer_d[i] = defer_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (mode_q[i] ? edge_ev[i] : lvl[i]) state_d[i] = ST_PEND;
                end
                ST_PEND: begin
                    if (claim_hit[i]) begin
                        state_d[i] = ST_SERV;
                        defer_d[i] = mode_q[i] && edge_ev[i];
                    end else if (!mode_q[i] && !lvl[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_SERV: begin
                    // Level is ignored while in service; it is re-examined from IDLE after complete
                    if (cmp_hit[i]) begin
                        state_d[i] = (defer_q[i] || (mode_q[i] && edge_ev[i])) ? ST_PEND : ST_IDLE;
                        defer_d[i] = 1'b0;
                    end else if (mode_q[i] && edge_ev[i]) begin
                        defer_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    defer_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) mei_d[i] = (state_d[i] == ST_PEND);
    end

    // Stage state: per-source FSM, deferred flags, mode and request outputs
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            mode_q  <= '0;
            defer_q <= '0;
            o_MEI   <= '0;
            for (int i = 0; i < N_SRC; i++) state_q[i] <= ST_IDLE;
        end else begin
            if (mode_wr) mode_q <= bus.i_WDATA[N_SRC-1:0];
            defer_q <= defer_d;
            o_MEI   <= mei_d;
            for (int i = 0; i < N_SRC; i++) state_q[i] <= state_d[i];
        end
    end

    assign o_IRQ_ANY = |o_MEI;

    always_comb begin
        rdata = '0;
        case (bus.i_ADDR)
            ADDR_MODE:      rdata[N_SRC-1:0] = mode_q;
            ADDR_PENDING:   rdata[N_SRC-1:0] = pend_vec;
            ADDR_CLAIM:     rdata[ID_W-1:0]  = claim_id;
            ADDR_INSERVICE: rdata[N_SRC-1:0] = serv_vec;
            default:        rdata = '0;
        endcase
    end

    assign bus.o_RDATA = rdata;
endmodule

// File: tb/tb_irq_gateway.sv
// Directed self-checking bench for irq_gateway: register map, capture modes, claim/complete, reset.
module tb_irq_gateway;
    localparam int N_SRC = 6;
`ifdef IRQ_GW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             i_CLK = 1'b0;
    logic             i_RSTn;
    logic [N_SRC-1:0] i_SRC;
    logic [N_SRC-1:0] o_MEI;
    logic             o_IRQ_ANY;
    int               vectors = 0;
    int               miscompares = 0;

    irq_gateway_if bus_if ();

    irq_gateway #(.N_SRC(N_SRC), .ID_W(3)) dut (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .i_SRC     (i_SRC),
        .bus       (bus_if.slave),
        .o_MEI     (o_MEI),
        .o_IRQ_ANY (o_IRQ_ANY)
    );

    always #5 i_CLK = ~i_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_CLK);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus_if.i_ADDR = a;
        #1;
        d = bus_if.o_RDATA;
    endtask

    task automatic claim(output logic [31:0] d);
        bus_if.i_ADDR = 5'h08;
        bus_if.i_RE   = 1'b1;
        #1;
        d = bus_if.o_RDATA;
        @(posedge i_CLK);
        #1;
        bus_if.i_RE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus_if.i_ADDR  = a;
        bus_if.i_WDATA = v;
        bus_if.i_WE    = 1'b1;
        @(posedge i_CLK);
        #1;
        bus_if.i_WE = 1'b0;
    endtask

    task automatic pulse(input logic [N_SRC-1:0] m);
        i_SRC = i_SRC | m;
        tick(1);
        i_SRC = i_SRC & ~m;
        tick(LAT + 1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        i_RSTn = 1'b0;
        i_SRC = '0;
        bus_if.i_RE = 1'b0;
        bus_if.i_WE = 1'b0;
        bus_if.i_ADDR = '0;
        bus_if.i_WDATA = '0;
        tick(2);
        for (int a = 0; a <= 16; a += 4) begin
            rd(5'(a), d);
            vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_reg_%0h: got %h want %h", a, d, 32'h0); end
        end
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL reset_mei: got %h want 00", o_MEI); end
        vectors++; if (o_IRQ_ANY !== 1'b0) begin miscompares++; $display("FAIL reset_any: got %b want 0", o_IRQ_ANY); end
        i_RSTn = 1'b1;
        tick(1);
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wr(5'h00, 32'h01);
        rd(5'h00, d);
        vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL edge_mode_rd: got %h want 01", d); end
        i_SRC = 6'h01;
        tick(1);
        i_SRC = 6'h00;
        tick(LAT - 1);
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL edge_lat_early: got %h want 00", o_MEI); end
        tick(1);
        vectors++; if (o_MEI !== 6'h01) begin miscompares++; $display("FAIL edge_lat_mei: got %h want 01", o_MEI); end
        vectors++; if (o_IRQ_ANY !== 1'b1) begin miscompares++; $display("FAIL edge_any: got %b want 1", o_IRQ_ANY); end
        rd(5'h08, d);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL edge_claim_peek: got %h want 1", d); end
        rd(5'h04, d);
        vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL edge_pend_after_peek: got %h want 01", d); end
        claim(d);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL edge_claim: got %h want 1", d); end
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL edge_mei_fall: got %h want 00", o_MEI); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL edge_inservice: got %h want 01", d); end
        wr(5'h0C, 32'h1);
        rd(5'h10, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL edge_complete: got %h want 0", d); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        wr(5'h00, 32'h00);
        i_SRC = 6'h14;
        tick(LAT + 1);
        rd(5'h04, d);
        vectors++; if (d !== 32'h14) begin miscompares++; $display("FAIL lvl_pending: got %h want 14", d); end
        vectors++; if (o_MEI !== 6'h14) begin miscompares++; $display("FAIL lvl_mei: got %h want 14", o_MEI); end
        claim(d);
        vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL lvl_claim_a: got %h want 3", d); end
        claim(d);
        vectors++; if (d !== 32'h5) begin miscompares++; $display("FAIL lvl_claim_b: got %h want 5", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h14) begin miscompares++; $display("FAIL lvl_inservice: got %h want 14", d); end
        wr(5'h0C, 32'h3);
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL lvl_pend_after_cmp: got %h want 00", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h10) begin miscompares++; $display("FAIL lvl_serv_after_cmp: got %h want 10", d); end
        tick(1);
        rd(5'h04, d);
        vectors++; if (d !== 32'h04) begin miscompares++; $display("FAIL lvl_reeval: got %h want 04", d); end
        claim(d);
        vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL lvl_reclaim: got %h want 3", d); end
        i_SRC = 6'h00;
        tick(LAT + 1);
        wr(5'h0C, 32'h3);
        wr(5'h0C, 32'h5);
        tick(1);
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL lvl_all_done: got %h want 00", d); end
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL lvl_none_pend: got %h want 00", d); end
        // Second run: source 4 retracts before it is claimed
        i_SRC = 6'h14;
        tick(LAT + 1);
        claim(d);
        vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL retract_claim_a: got %h want 3", d); end
        i_SRC = 6'h04;
        tick(LAT + 1);
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL retract_pending: got %h want 00", d); end
        claim(d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL retract_claim_none: got %h want 0", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h04) begin miscompares++; $display("FAIL retract_inservice: got %h want 04", d); end
        i_SRC = 6'h00;
        tick(LAT + 1);
        wr(5'h0C, 32'h3);
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL retract_done: got %h want 00", d); end
    endtask

    task automatic test_deferred();
        logic [31:0] d;
        wr(5'h00, 32'h02);
        pulse(6'h02);
        claim(d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL defer_claim: got %h want 2", d); end
        pulse(6'h02);
        pulse(6'h02);
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL defer_pending_held: got %h want 00", d); end
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL defer_mei_held: got %h want 00", o_MEI); end
        wr(5'h0C, 32'h2);
        rd(5'h04, d);
        vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL defer_repend: got %h want 02", d); end
        vectors++; if (o_MEI !== 6'h02) begin miscompares++; $display("FAIL defer_mei: got %h want 02", o_MEI); end
        claim(d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL defer_reclaim: got %h want 2", d); end
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL defer_mei_fall: got %h want 00", o_MEI); end
        wr(5'h0C, 32'h2);
        tick(2);
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL defer_once: got %h want 00", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL defer_idle: got %h want 00", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        pulse(6'h02);
        claim(d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL sim_claim: got %h want 2", d); end
        // Complete lands on the same edge as the edge event
        i_SRC = 6'h02;
        tick(LAT);
        wr(5'h0C, 32'h2);
        i_SRC = 6'h00;
        rd(5'h04, d);
        vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL sim_cmp_edge_pend: got %h want 02", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL sim_cmp_edge_serv: got %h want 00", d); end
        tick(LAT + 1);
        // Claim lands on the same edge as the edge event
        i_SRC = 6'h02;
        tick(LAT);
        claim(d);
        i_SRC = 6'h00;
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL sim_claim_edge_id: got %h want 2", d); end
        tick(LAT + 1);
        rd(5'h04, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL sim_claim_edge_pend: got %h want 00", d); end
        wr(5'h0C, 32'h2);
        rd(5'h04, d);
        vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL sim_claim_edge_defer: got %h want 02", d); end
        claim(d);
        wr(5'h0C, 32'h2);
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL sim_cleanup: got %h want 00", d); end
    endtask

    task automatic test_bad_complete();
        logic [31:0] d;
        wr(5'h00, 32'h03);
        pulse(6'h01);
        claim(d);
        pulse(6'h02);
        wr(5'h0C, 32'h0);
        wr(5'h0C, 32'h7);
        wr(5'h0C, 32'hFFFF_FFF8);
        wr(5'h0C, 32'h2);
        wr(5'h0C, 32'h4);
        wr(5'h14, 32'hFFFF_FFFF);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h10, 32'hFFFF_FFFF);
        rd(5'h00, d);
        vectors++; if (d !== 32'h03) begin miscompares++; $display("FAIL bad_mode: got %h want 03", d); end
        rd(5'h04, d);
        vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL bad_pending: got %h want 02", d); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL bad_inservice: got %h want 01", d); end
        rd(5'h14, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL bad_unmapped: got %h want 00", d); end
        vectors++; if (o_MEI !== 6'h02) begin miscompares++; $display("FAIL bad_mei: got %h want 02", o_MEI); end
        wr(5'h0C, 32'h1);
        claim(d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL bad_cleanup_claim: got %h want 2", d); end
        wr(5'h0C, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(5'h00, 32'h08);
        pulse(6'h08);
        claim(d);
        vectors++; if (d !== 32'h4) begin miscompares++; $display("FAIL rst_claim: got %h want 4", d); end
        pulse(6'h08);
        wr(5'h00, 32'h09);
        pulse(6'h01);
        vectors++; if (o_MEI !== 6'h01) begin miscompares++; $display("FAIL rst_pre_mei: got %h want 01", o_MEI); end
        i_RSTn = 1'b0;
        #1;
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL rst_async_mei: got %h want 00", o_MEI); end
        vectors++; if (o_IRQ_ANY !== 1'b0) begin miscompares++; $display("FAIL rst_async_any: got %b want 0", o_IRQ_ANY); end
        rd(5'h10, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL rst_async_serv: got %h want 00", d); end
        rd(5'h00, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL rst_async_mode: got %h want 00", d); end
        tick(1);
        i_RSTn = 1'b1;
        wr(5'h00, 32'h08);
        tick(3);
        vectors++; if (o_MEI !== 6'h00) begin miscompares++; $display("FAIL rst_no_defer: got %h want 00", o_MEI); end
        pulse(6'h08);
        vectors++; if (o_MEI !== 6'h08) begin miscompares++; $display("FAIL rst_fresh_edge: got %h want 08", o_MEI); end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_deferred();
        test_simultaneous();
        test_bad_complete();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
